// File: rtl/stream_rl1_sink_fifo.sv
// stream_rl1_sink_fifo
//   Sink for a ready-latency-1 video stream (24b RGB + SOP + EOP). A small
//   skid FIFO absorbs the beat still in flight after ready_out drops and
//   re-presents the data as a ready-latency-0, first-word-fall-through stream.
//   Define STREAM_RL1_SINK_PKT_CHECK_EN to build the SOP/EOP framing checker;
//   without it err_sop, err_eop, pkt_len and pkt_done are tied to zero.
module stream_rl1_sink_fifo #(
  parameter int DATA_WIDTH = 26,
  parameter int DEPTH      = 4,
  parameter int SOP_BIT    = 24,
  parameter int EOP_BIT    = 25,
  parameter int LEN_WIDTH  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ready_in,
  output logic                  overflow,
  output logic                  err_sop,
  output logic                  err_eop,
  output logic [LEN_WIDTH-1:0]  pkt_len,
  output logic                  pkt_done
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(DEPTH - 2);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full      = (count == CNT_FULL);
  assign pop       = valid_out & ready_in;
  assign push      = valid_in & (~full | pop);

  // Room is reserved for the beat granted last cycle plus the one granted now.
  assign ready_out = ~rst & (count <= CNT_READY);
  assign valid_out = (count != '0);
  assign data_out  = mem[rd_ptr];

  // Explicit wrap so that non-power-of-two depths work.
  always_comb begin
    rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
    wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
  end

  // Occupancy and pointer bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_nxt;
      if (pop)  rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage; cleared on reset so data_out reads zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Sticky flag for a beat that arrived with no slot to take it.
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (valid_in & full & ~pop) overflow <= 1'b1;
  end

`ifdef STREAM_RL1_SINK_PKT_CHECK_EN
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [0:0]           state;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] len_inc;
  logic                 sop_in;
  logic                 eop_in;

  assign sop_in  = data_in[SOP_BIT];
  assign eop_in  = data_in[EOP_BIT];
  assign len_inc = (&len) ? len : len + 1'b1;

  // Framing checker, evaluated only on beats actually accepted into the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len      <= '0;
      pkt_len  <= '0;
      pkt_done <= 1'b0;
      err_sop  <= 1'b0;
      err_eop  <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (push) begin
        if (sop_in) begin
          // A SOP inside an open packet abandons it and starts a new one.
          if (state == ST_IN_PKT) err_eop <= 1'b1;
          len <= LEN_WIDTH'(1);
          if (eop_in) begin
            pkt_len  <= LEN_WIDTH'(1);
            pkt_done <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            state <= ST_IN_PKT;
          end
        end else if (state == ST_IDLE) begin
          err_sop <= 1'b1;
        end else begin
          len <= len_inc;
          if (eop_in) begin
            pkt_len  <= len_inc;
            pkt_done <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      end
    end
  end
`else
  assign err_sop  = 1'b0;
  assign err_eop  = 1'b0;
  assign pkt_len  = '0;
  assign pkt_done = 1'b0;
`endif

endmodule
